offset_decode_rx: RTL and testbench

// - Receive end of the register -> +OFFSET -> register data path.
// - Accepts incremented words over a valid/ready handshake and removes the offset (out = in - OFFSET).
// - Buffers decoded words in a DEPTH-entry FIFO and presents them downstream over valid/ready.
// - Optional checker flags breaks in the expected +1 word sequence.
//

---
 rtl/offset_decode_rx.sv | 143 ++++++++++++++
 tb/tb_offset_decode_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/offset_decode_rx.sv
// Receive side of the +OFFSET link: subtracts OFFSET from each incoming word and buffers it in a DEPTH-entry FIFO.
// Optional sequence checker enabled by defining OFFSET_DECODE_RX_SEQ_CHECK_EN.
module offset_decode_rx #(
    parameter int          DW     = 8,
    parameter int          DEPTH  = 4,
    parameter int unsigned OFFSET = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DW-1:0]                in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DW-1:0]                out_data,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         seq_err,
    output logic [7:0]                   err_count
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [DW-1:0] OFF_W  = DW'(OFFSET);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;

    logic          push;
    logic          pop;
    logic [DW-1:0] dec_data;

    always_comb begin
        push     = in_valid & in_ready_q;
        pop      = out_valid_q & out_ready;
        dec_data = in_data - OFF_W;

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // Handshake flags come from the next occupancy so they are pure flop outputs.
        in_ready_d  = (level_d != FULL_LVL);
        out_valid_d = (level_d != '0);

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = dec_data;
        end

        // The word being written becomes the head when it lands at the new read pointer.
        if (level_d == '0) begin
            out_data_d = out_data_q;
        end else if (push && (wr_ptr_q == rd_ptr_d)) begin
            out_data_d = dec_data;
        end else begin
            out_data_d = mem_q[rd_ptr_d];
        end
    end

    // NOTE: storage has no reset; only the pointers and level decide what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // NOTE: every state flop uses <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign level     = level_q;

`ifdef OFFSET_DECODE_RX_SEQ_CHECK_EN
    logic [DW-1:0] expected_q, expected_d;
    logic          exp_valid_q, exp_valid_d;
    logic          seq_err_q, seq_err_d;
    logic [7:0]    err_count_q, err_count_d;
    logic          mismatch;

    always_comb begin
        mismatch    = push & exp_valid_q & (dec_data != expected_q);
        expected_d  = expected_q;
        exp_valid_d = exp_valid_q;
        if (push) begin
            expected_d  = dec_data + DW'(1);
            exp_valid_d = 1'b1;
        end
        seq_err_d   = mismatch;
        err_count_d = err_count_q;
        if (mismatch && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            expected_q  <= '0;
            exp_valid_q <= 1'b0;
            seq_err_q   <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            expected_q  <= expected_d;
            exp_valid_q <= exp_valid_d;
            seq_err_q   <= seq_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign seq_err   = seq_err_q;
    assign err_count = err_count_q;
`else
    assign seq_err   = 1'b0;
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_offset_decode_rx.sv
// Scoreboard bench for offset_decode_rx: a negedge monitor models the FIFO and compares every output each cycle.
module tb_offset_decode_rx;

    localparam int DW     = 8;
    localparam int DEPTH  = 4;
    localparam int OFFSET = 1;
    localparam int AW     = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW:0]   level;
    logic          seq_err;
    logic [7:0]    err_count;

    int checks = 0;
    int errors = 0;

    offset_decode_rx #(.DW(DW), .DEPTH(DEPTH), .OFFSET(OFFSET)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .seq_err   (seq_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard model state
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] last_out  = '0;
    logic          last_rst  = 1'b1;
    logic          mon_on    = 1'b0;
    logic          exp_valid = 1'b0;
    logic [DW-1:0] expected  = '0;
    logic          exp_seq   = 1'b0;
    logic [7:0]    exp_cnt   = 8'h00;
    logic          m_in_ready, m_out_valid, m_push, m_pop, m_mism;
    logic [DW-1:0] m_dec;

    always @(negedge clk) begin
        m_in_ready  = !last_rst && (sb_q.size() != DEPTH);
        m_out_valid = (sb_q.size() != 0);
        if (mon_on) begin
            check("level", 32'(level), 32'(sb_q.size()));
            check("out_valid", 32'(out_valid), 32'(m_out_valid));
            check("in_ready", 32'(in_ready), 32'(m_in_ready));
            check("out_data", 32'(out_data), 32'(m_out_valid ? sb_q[0] : last_out));
            check("seq_err", 32'(seq_err), 32'(exp_seq));
            check("err_count", 32'(err_count), 32'(exp_cnt));
        end
        m_push = in_valid && m_in_ready && !rst;
        m_pop  = m_out_valid && out_ready && !rst;
        m_dec  = in_data - DW'(OFFSET);
        if (rst) begin
            sb_q.delete();
            last_out  = '0;
            exp_valid = 1'b0;
            exp_seq   = 1'b0;
            exp_cnt   = 8'h00;
        end else begin
            exp_seq = 1'b0;
            if (m_pop) last_out = sb_q.pop_front();
            if (m_push) begin
                sb_q.push_back(m_dec);
`ifdef OFFSET_DECODE_RX_SEQ_CHECK_EN
                m_mism = exp_valid && (m_dec != expected);
                if (m_mism) begin
                    exp_seq = 1'b1;
                    if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
                end
                expected  = m_dec + DW'(1);
                exp_valid = 1'b1;
`endif
            end
        end
        last_rst = rst;
    end

    // Holds in_valid until the word is taken; inputs change 1ns after the rising edge.
    task automatic push_word(input logic [DW-1:0] d);
        bit taken = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50 && !taken; i++) begin
            @(negedge clk);
            if (in_ready) taken = 1;
            @(posedge clk);
            #1;
        end
        if (!taken) check("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
    endtask

    task automatic drain();
        bit empty = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && !empty; i++) begin
            @(negedge clk);
            if (!out_valid) empty = 1;
            @(posedge clk);
            #1;
        end
        if (!empty) check("drain_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held 3 cycles
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_level", 32'(level), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        // Stream with a ready sink
        out_ready = 1'b1;
        push_word(8'h01);
        push_word(8'h02);
        push_word(8'h03);
        idle(3);

        // Full and back-pressure
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_word(8'h40 + DW'(i));
        in_valid = 1'b1;
        in_data  = 8'h44;
        idle(2);
        @(negedge clk);
        check("full_level", 32'(level), DEPTH);
        check("full_in_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        push_word(8'h44);
        drain();

        // Underflow wrap of the decode, then pointer wrap with level held at 1
        push_word(8'h00);
        @(negedge clk);
        check("wrap_ff", 32'(out_data), 32'hFF);
        @(posedge clk);
        #1;
        push_word(8'h20);
        for (int i = 0; i < 10; i++) push_word(8'h80 + DW'(i));
        drain();

        // Mid-stream reset discards buffered words
        out_ready = 1'b0;
        push_word(8'h55);
        push_word(8'h66);
        push_word(8'h77);
        do_reset(1);
        out_ready = 1'b1;
        idle(2);
        @(negedge clk);
        check("mrst_level", 32'(level), 0);
        check("mrst_valid", 32'(out_valid), 0);
        idle(4);

        // Sequence checker: decoded 10,11,13,14 then 300 deliberate breaks
        do_reset(2);
        idle(1);
        push_word(8'h11);
        push_word(8'h12);
        push_word(8'h14);
        push_word(8'h15);
        idle(2);
        @(negedge clk);
`ifdef OFFSET_DECODE_RX_SEQ_CHECK_EN
        check("seq_count1", 32'(err_count), 32'h01);
`else
        check("seq_count1", 32'(err_count), 32'h00);
`endif
        for (int i = 0; i < 300; i++) push_word(8'h01);
        idle(2);
        @(negedge clk);
`ifdef OFFSET_DECODE_RX_SEQ_CHECK_EN
        check("seq_sat", 32'(err_count), 32'hFF);
`else
        check("seq_sat", 32'(err_count), 32'h00);
`endif
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
